contador_prog: RTL and testbench

Programmable, parametrised up/down counter/timer that generalises the loadable 4-bit decrement counter.
- Adds width, direction, a prescaler and three terminal-count modes (saturate, wrap, auto-reload).
- Provides start/stop control and status outputs.
- Serves as the countdown/timeout primitive for the control FSMs in the system datapath.

---
 rtl/contador_prog_if.sv | 29 ++
 rtl/contador_prog.sv | 107 ++++++++++
 tb/tb_contador_prog.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/contador_prog_if.sv
// Control/status bundle for contador_prog; irq/irq_clr exist only with CONTADOR_PROG_IRQ_EN.
interface contador_prog_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             busy;
`ifdef CONTADOR_PROG_IRQ_EN
    logic             irq_clr;
    logic             irq;

    modport master (output load, load_val, start, stop, dir, mode, irq_clr,
                    input  count, zero, tc, busy, irq);
    modport slave  (input  load, load_val, start, stop, dir, mode, irq_clr,
                    output count, zero, tc, busy, irq);
`else
    modport master (output load, load_val, start, stop, dir, mode,
                    input  count, zero, tc, busy);
    modport slave  (input  load, load_val, start, stop, dir, mode,
                    output count, zero, tc, busy);
`endif
endinterface

// File: rtl/contador_prog.sv
// Programmable up/down counter/timer with prescaler and saturate/wrap/auto-reload modes.
// Optional sticky interrupt enabled by defining CONTADOR_PROG_IRQ_EN.
module contador_prog #(
    parameter int WIDTH          = 4,
    parameter int RELOAD_DEFAULT = 4,
    parameter int PRESCALE       = 1
) (
    input  logic           clk,
    input  logic           rst,
    contador_prog_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESCALE_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] RESET_VAL    = WIDTH'(RELOAD_DEFAULT);
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state, state_d;
    logic [WIDTH-1:0] count, count_d;
    logic [WIDTH-1:0] reload, reload_d;
    logic [PW-1:0]    presc, presc_d;
    logic             tc, tc_d;
    logic             busy;
    logic [WIDTH-1:0] terminal;

    assign terminal = bus.dir ? '1 : '0;

    // load only touches count/reload/prescaler; stop/start still steer the state
    // in the same cycle, and any of the three suppresses a step.
    always_comb begin
        state_d  = state;
        count_d  = count;
        reload_d = reload;
        presc_d  = presc;
        tc_d     = 1'b0;
        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            presc_d  = '0;
        end
        if (bus.stop) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (bus.start && state != RUN) begin
            state_d = RUN;
            presc_d = '0;
        end else if (!bus.load && state == RUN) begin
            if (presc == PRESCALE_MAX) begin
                presc_d = '0;
                if (count == terminal) begin
                    tc_d = 1'b1;
                    case (bus.mode)
                        2'b01:   count_d = bus.dir ? count + ONE : count - ONE;
                        2'b10:   count_d = reload;
                        default: state_d = DONE;
                    endcase
                end else begin
                    count_d = bus.dir ? count + ONE : count - ONE;
                end
            end else begin
                presc_d = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= RESET_VAL;
            reload <= RESET_VAL;
            presc  <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            reload <= reload_d;
            presc  <= presc_d;
            tc     <= tc_d;
            busy   <= (state_d == RUN);
        end
    end

`ifdef CONTADOR_PROG_IRQ_EN
    logic irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else if (tc_d) begin
            irq <= 1'b1;
        end else if (bus.irq_clr) begin
            irq <= 1'b0;
        end
    end

    assign bus.irq = irq;
`endif

    assign bus.count = count;
    assign bus.zero  = (count == '0);
    assign bus.tc    = tc;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_contador_prog.sv
// Directed bench for contador_prog: WIDTH=4/PRESCALE=1 and WIDTH=8/PRESCALE=3 instances.
module tb_contador_prog;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    contador_prog_if #(.WIDTH(4)) bus4 ();
    contador_prog_if #(.WIDTH(8)) bus8 ();

    contador_prog #(.WIDTH(4), .RELOAD_DEFAULT(4), .PRESCALE(1)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    contador_prog #(.WIDTH(8), .RELOAD_DEFAULT(4), .PRESCALE(3)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus4.count !== 4'd4 || bus4.busy !== 1'b0 || bus4.tc !== 1'b0 || bus4.zero !== 1'b0) begin
            failures++;
            $display("FAIL reset4 count=%0d busy=%b tc=%b zero=%b required 4/0/0/0",
                     bus4.count, bus4.busy, bus4.tc, bus4.zero);
        end
        checks++;
        if (bus8.count !== 8'd4 || bus8.busy !== 1'b0 || bus8.tc !== 1'b0) begin
            failures++;
            $display("FAIL reset8 count=%0d busy=%b tc=%b required 4/0/0",
                     bus8.count, bus8.busy, bus8.tc);
        end
        rst = 1'b1;
    endtask

    task automatic test_saturate();
        int exp_c[7] = '{4, 3, 2, 1, 0, 0, 0};
        int exp_t[7] = '{0, 0, 0, 0, 0, 1, 0};
        int exp_b[7] = '{1, 1, 1, 1, 1, 0, 0};
        int pulses = 0;
        @(negedge clk);
        bus4.load = 1'b1; bus4.load_val = 4'd4; bus4.dir = 1'b0; bus4.mode = 2'b00;
        @(negedge clk);
        bus4.load = 1'b0; bus4.start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus4.start = 1'b0;
            pulses += int'(bus4.tc);
            checks++;
            if (bus4.count !== 4'(exp_c[i]) || bus4.tc !== 1'(exp_t[i]) || bus4.busy !== 1'(exp_b[i])) begin
                failures++;
                $display("FAIL saturate[%0d] count=%0d tc=%b busy=%b required %0d/%0d/%0d",
                         i, bus4.count, bus4.tc, bus4.busy, exp_c[i], exp_t[i], exp_b[i]);
            end
        end
        checks++;
        if (pulses != 1 || bus4.zero !== 1'b1) begin
            failures++;
            $display("FAIL saturate_end pulses=%0d zero=%b required 1/1", pulses, bus4.zero);
        end
    endtask

    task automatic test_wrap();
        int exp_c[5] = '{14, 15, 0, 1, 2};
        int exp_t[5] = '{0, 0, 1, 0, 0};
        @(negedge clk);
        bus4.load = 1'b1; bus4.load_val = 4'd14; bus4.dir = 1'b1; bus4.mode = 2'b01;
        @(negedge clk);
        bus4.load = 1'b0; bus4.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus4.start = 1'b0;
            checks++;
            if (bus4.count !== 4'(exp_c[i]) || bus4.tc !== 1'(exp_t[i]) || bus4.busy !== 1'b1) begin
                failures++;
                $display("FAIL wrap[%0d] count=%0d tc=%b busy=%b required %0d/%0d/1",
                         i, bus4.count, bus4.tc, bus4.busy, exp_c[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_load_stop();
        int exp_c[5] = '{9, 8, 7, 6, 5};
        bus4.load = 1'b1; bus4.load_val = 4'd9; bus4.stop = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.count !== 4'd9 || bus4.busy !== 1'b0 || bus4.tc !== 1'b0) begin
            failures++;
            $display("FAIL load_stop count=%0d busy=%b tc=%b required 9/0/0",
                     bus4.count, bus4.busy, bus4.tc);
        end
        bus4.load = 1'b0; bus4.stop = 1'b0; bus4.dir = 1'b0; bus4.mode = 2'b00; bus4.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus4.start = 1'b0;
            checks++;
            if (bus4.count !== 4'(exp_c[i]) || bus4.busy !== 1'b1) begin
                failures++;
                $display("FAIL resume[%0d] count=%0d busy=%b required %0d/1",
                         i, bus4.count, bus4.busy, exp_c[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus4.count !== 4'd4 || bus4.busy !== 1'b0 || bus4.tc !== 1'b0) begin
            failures++;
            $display("FAIL async_reset count=%0d busy=%b tc=%b required 4/0/0",
                     bus4.count, bus4.busy, bus4.tc);
        end
        @(negedge clk);
        checks++;
        if (bus4.count !== 4'd4 || bus4.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold count=%0d busy=%b required 4/0", bus4.count, bus4.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus4.count !== 4'd4 || bus4.busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle count=%0d busy=%b required 4/0", bus4.count, bus4.busy);
        end
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus4.count !== 4'd3 || bus4.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart count=%0d busy=%b required 3/1", bus4.count, bus4.busy);
        end
    endtask

    task automatic test_reserved_mode();
        int exp_t[3] = '{0, 1, 0};
        int exp_b[3] = '{1, 0, 0};
        bus4.load = 1'b1; bus4.load_val = 4'd15; bus4.dir = 1'b1; bus4.mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus4.load = 1'b0;
            checks++;
            if (bus4.count !== 4'd15 || bus4.tc !== 1'(exp_t[i]) || bus4.busy !== 1'(exp_b[i])) begin
                failures++;
                $display("FAIL reserved[%0d] count=%0d tc=%b busy=%b required 15/%0d/%0d",
                         i, bus4.count, bus4.tc, bus4.busy, exp_t[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_prescale();
        int exp_c[19] = '{2, 2, 2, 1, 1, 1, 0, 0, 0, 2, 2, 2, 1, 1, 1, 0, 0, 0, 2};
        int pulses = 0;
        @(negedge clk);
        bus8.load = 1'b1; bus8.load_val = 8'd2; bus8.dir = 1'b0; bus8.mode = 2'b10;
        @(negedge clk);
        bus8.load = 1'b0; bus8.start = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            pulses += int'(bus8.tc);
            checks++;
            if (bus8.count !== 8'(exp_c[i]) || bus8.tc !== ((i == 9) || (i == 18)) || bus8.busy !== 1'b1) begin
                failures++;
                $display("FAIL prescale[%0d] count=%0d tc=%b busy=%b required %0d/%b/1",
                         i, bus8.count, bus8.tc, bus8.busy, exp_c[i], (i == 9) || (i == 18));
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL prescale_pulses got=%0d required 2", pulses);
        end
        bus8.stop = 1'b1;
        @(negedge clk);
        bus8.stop = 1'b0;
    endtask

`ifdef CONTADOR_PROG_IRQ_EN
    task automatic test_irq();
        bus4.irq_clr = 1'b1;
        @(negedge clk);
        bus4.irq_clr = 1'b0;
        checks++;
        if (bus4.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear got=%b required 0", bus4.irq);
        end
        bus4.load = 1'b1; bus4.load_val = 4'd1; bus4.dir = 1'b0; bus4.mode = 2'b00;
        @(negedge clk);
        bus4.load = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.irq_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.irq !== 1'b1 || bus4.tc !== 1'b1) begin
            failures++;
            $display("FAIL irq_set_wins irq=%b tc=%b required 1/1", bus4.irq, bus4.tc);
        end
        @(negedge clk);
        bus4.irq_clr = 1'b0;
        checks++;
        if (bus4.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clr_alone got=%b required 0", bus4.irq);
        end
    endtask
`endif

    initial begin
        bus4.load = 1'b0; bus4.load_val = '0; bus4.start = 1'b0; bus4.stop = 1'b0;
        bus4.dir = 1'b0; bus4.mode = 2'b00;
        bus8.load = 1'b0; bus8.load_val = '0; bus8.start = 1'b0; bus8.stop = 1'b0;
        bus8.dir = 1'b0; bus8.mode = 2'b00;
`ifdef CONTADOR_PROG_IRQ_EN
        bus4.irq_clr = 1'b0;
        bus8.irq_clr = 1'b0;
`endif
        test_reset();
        test_saturate();
        test_wrap();
        test_load_stop();
        test_async_reset();
        test_reserved_mode();
        test_prescale();
`ifdef CONTADOR_PROG_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
